// File: rtl/ring_xfer_ctrl.sv
// Ring transfer sequencer: programs the router direction/bypass once per
// descriptor and meters SLDU<->router valid/ready beats until completion.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_*                     descriptor handshake (dir, bypass, tx/rx beats)
//   flush_i                   abort any transfer, back to IDLE
//   busy_o, done_o            status; done_o is a one-cycle pulse
//   dir_o, bypass_o           router configuration, held between configs
//   conf_valid_o              router configuration strobe
//   sldu_tx_*, rtr_tx_*       gated SLDU -> router handshake
//   rtr_rx_*, sldu_rx_*       gated router -> SLDU handshake
module ring_xfer_ctrl #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_dir_i,
  input  logic                req_bypass_i,
  input  logic [CntWidth-1:0] req_tx_beats_i,
  input  logic [CntWidth-1:0] req_rx_beats_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                dir_o,
  output logic                bypass_o,
  output logic                conf_valid_o,
  input  logic                sldu_tx_valid_i,
  output logic                sldu_tx_ready_o,
  output logic                rtr_tx_valid_o,
  input  logic                rtr_tx_ready_i,
  input  logic                rtr_rx_valid_i,
  output logic                rtr_rx_ready_o,
  output logic                sldu_rx_valid_o,
  input  logic                sldu_rx_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    CONFIG,
    XFER
  } state_e;

  state_e state_q;

  logic [CntWidth-1:0] tx_beats_q;
  logic [CntWidth-1:0] rx_beats_q;
  logic [CntWidth-1:0] tx_cnt_q;
  logic [CntWidth-1:0] rx_cnt_q;
  logic [CntWidth-1:0] tx_cnt_n;
  logic [CntWidth-1:0] rx_cnt_n;

  logic kill;
  logic accept;
  logic in_cfg;
  logic in_xfer;
  logic tx_open;
  logic rx_open;
  logic tx_fire;
  logic rx_fire;
  logic no_beats;
  logic cfg_done;
  logic xfer_done;

  // Reset held low closes every path exactly like a flush.
  assign kill = flush_i | ~rst_ni;

  assign req_ready_o = (state_q == IDLE) & ~kill;
  assign accept      = req_valid_i & req_ready_o;

  assign in_cfg  = (state_q == CONFIG) & ~kill;
  assign in_xfer = (state_q == XFER) & ~kill;

  // Counters stop at their targets, so inequality means "beats left".
  assign tx_open = in_xfer & (tx_cnt_q != tx_beats_q);
  assign rx_open = in_xfer & (rx_cnt_q != rx_beats_q);

  assign rtr_tx_valid_o  = tx_open & sldu_tx_valid_i;
  assign sldu_tx_ready_o = tx_open & rtr_tx_ready_i;
  assign sldu_rx_valid_o = rx_open & rtr_rx_valid_i;
  assign rtr_rx_ready_o  = rx_open & sldu_rx_ready_i;

  assign tx_fire = tx_open & sldu_tx_valid_i & rtr_tx_ready_i;
  assign rx_fire = rx_open & rtr_rx_valid_i & sldu_rx_ready_i;

  assign tx_cnt_n = tx_cnt_q + CntWidth'(tx_fire);
  assign rx_cnt_n = rx_cnt_q + CntWidth'(rx_fire);

  assign no_beats = (tx_beats_q == '0) & (rx_beats_q == '0);

  // bypass_o already carries the latched bypass during CONFIG.
  assign cfg_done = in_cfg & (bypass_o | no_beats);

  // Completion looks at post-handshake counts so done_o rides the
  // final beat rather than trailing it by a cycle.
  assign xfer_done = in_xfer
                   & (tx_cnt_n == tx_beats_q)
                   & (rx_cnt_n == rx_beats_q);

  assign conf_valid_o = in_cfg;
  assign done_o       = cfg_done | xfer_done;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_beats_q <= '0;
      rx_beats_q <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      dir_o      <= 1'b0;
      bypass_o   <= 1'b0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dir_o      <= req_dir_i;
            bypass_o   <= req_bypass_i;
            tx_beats_q <= req_tx_beats_i;
            rx_beats_q <= req_rx_beats_i;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            state_q    <= CONFIG;
          end
        end
        CONFIG: begin
          state_q <= cfg_done ? IDLE : XFER;
        end
        XFER: begin
          tx_cnt_q <= tx_cnt_n;
          rx_cnt_q <= rx_cnt_n;
          if (xfer_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_xfer_ctrl.sv
// Directed/randomised bench for ring_xfer_ctrl with a descriptor
// scoreboard that checks beat counts and config at each done pulse.
module tb_ring_xfer_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_dir_i;
  logic          req_bypass_i;
  logic [CW-1:0] req_tx_beats_i;
  logic [CW-1:0] req_rx_beats_i;
  logic          flush_i;
  logic          busy_o;
  logic          done_o;
  logic          dir_o;
  logic          bypass_o;
  logic          conf_valid_o;
  logic          sldu_tx_valid_i;
  logic          sldu_tx_ready_o;
  logic          rtr_tx_valid_o;
  logic          rtr_tx_ready_i;
  logic          rtr_rx_valid_i;
  logic          rtr_rx_ready_o;
  logic          sldu_rx_valid_o;
  logic          sldu_rx_ready_i;

  ring_xfer_ctrl #(.CntWidth(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_dir_i       (req_dir_i),
    .req_bypass_i    (req_bypass_i),
    .req_tx_beats_i  (req_tx_beats_i),
    .req_rx_beats_i  (req_rx_beats_i),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .dir_o           (dir_o),
    .bypass_o        (bypass_o),
    .conf_valid_o    (conf_valid_o),
    .sldu_tx_valid_i (sldu_tx_valid_i),
    .sldu_tx_ready_o (sldu_tx_ready_o),
    .rtr_tx_valid_o  (rtr_tx_valid_o),
    .rtr_tx_ready_i  (rtr_tx_ready_i),
    .rtr_rx_valid_i  (rtr_rx_valid_i),
    .rtr_rx_ready_o  (rtr_rx_ready_o),
    .sldu_rx_valid_o (sldu_rx_valid_o),
    .sldu_rx_ready_i (sldu_rx_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          dir;
    logic          byp;
    logic [CW-1:0] tx;
    logic [CW-1:0] rx;
  } desc_t;

  desc_t exp_q[$];
  int    tx_seen = 0;
  int    rx_seen = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic gates();
    return rtr_tx_valid_o | sldu_tx_ready_o | rtr_rx_ready_o | sldu_rx_valid_o;
  endfunction

  // Scoreboard: descriptors pushed on acceptance, popped on done_o.
  always @(negedge clk) begin
    desc_t d;
    int    lim;
    logic  txr, txs, rxr, rxs;
    #2;
    if (!rst_ni || flush_i) begin
      exp_q.delete();
      tx_seen = 0;
      rx_seen = 0;
    end else begin
      txr = rtr_tx_valid_o & rtr_tx_ready_i;
      txs = sldu_tx_valid_i & sldu_tx_ready_o;
      rxr = rtr_rx_valid_i & rtr_rx_ready_o;
      rxs = sldu_rx_valid_o & sldu_rx_ready_i;
      if (txr | txs) begin
        chk("tx_hs_pair", txs, txr);
        chki("tx_hs_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          d = exp_q[0];
          lim = d.byp ? 0 : int'(d.tx);
          chk("tx_overrun", tx_seen < lim, 1'b1);
        end
        tx_seen++;
      end
      if (rxr | rxs) begin
        chk("rx_hs_pair", rxs, rxr);
        chki("rx_hs_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          d = exp_q[0];
          lim = d.byp ? 0 : int'(d.rx);
          chk("rx_overrun", rx_seen < lim, 1'b1);
        end
        rx_seen++;
      end
      if (conf_valid_o) begin
        chki("conf_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("conf_dir", dir_o, exp_q[0].dir);
          chk("conf_bypass", bypass_o, exp_q[0].byp);
        end
      end
      if (done_o) begin
        chki("done_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          chki("done_tx_beats", tx_seen, d.byp ? 0 : int'(d.tx));
          chki("done_rx_beats", rx_seen, d.byp ? 0 : int'(d.rx));
        end
        chk("done_no_accept", req_ready_o, 1'b0);
        tx_seen = 0;
        rx_seen = 0;
      end
      if (req_valid_i && req_ready_o) begin
        d.dir = req_dir_i;
        d.byp = req_bypass_i;
        d.tx  = req_tx_beats_i;
        d.rx  = req_rx_beats_i;
        exp_q.push_back(d);
        tx_seen = 0;
        rx_seen = 0;
      end
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic req(input logic dir, input logic byp,
                     input int tx, input int rx);
    req_valid_i    = 1'b1;
    req_dir_i      = dir;
    req_bypass_i   = byp;
    req_tx_beats_i = tx[CW-1:0];
    req_rx_beats_i = rx[CW-1:0];
  endtask

  task automatic hs(input logic tv, input logic tr,
                    input logic rv, input logic rr);
    sldu_tx_valid_i = tv;
    rtr_tx_ready_i  = tr;
    rtr_rx_valid_i  = rv;
    sldu_rx_ready_i = rr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, ntx, nrx, post;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    req(0, 0, 0, 0);
    req_valid_i = 1'b0;
    hs(1, 1, 1, 1);
    nx();
    nx();
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_dir", dir_o, 1'b0);
    chk("rst_bypass", bypass_o, 1'b0);
    chk("rst_conf", conf_valid_o, 1'b0);
    chk("rst_gates", gates(), 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b0);
    nx();
    rst_ni = 1'b1;
    hs(0, 0, 0, 0);
    #1;
    chk("idle_req_ready", req_ready_o, 1'b1);

    // 4/4 beats, everything always ready
    nx();
    req(0, 0, 4, 4);
    hs(1, 1, 1, 1);
    #1;
    chk("t1_req_ready", req_ready_o, 1'b1);
    nx();
    req_valid_i = 1'b0;
    #1;
    chk("t1_conf", conf_valid_o, 1'b1);
    chk("t1_dir", dir_o, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_cfg_done", done_o, 1'b0);
    chk("t1_cfg_gates", gates(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      nx();
      #1;
      chk("t1_tx_valid", rtr_tx_valid_o, 1'b1);
      chk("t1_rx_valid", sldu_rx_valid_o, 1'b1);
      chk("t1_done", done_o, i == 3);
    end
    nx();
    #1;
    chk("t1_busy_drop", busy_o, 1'b0);
    chk("t1_done_drop", done_o, 1'b0);
    chk("t1_gates_idle", gates(), 1'b0);

    // tx=3 rx=1, rx beat held back
    nx();
    req(1, 0, 3, 1);
    hs(1, 1, 0, 1);
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    chk("t2_conf", conf_valid_o, 1'b1);
    chk("t2_dir", dir_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nx();
      #1;
      chk("t2_tx_valid", rtr_tx_valid_o, 1'b1);
      chk("t2_rx_ready", rtr_rx_ready_o, 1'b1);
      chk("t2_done_early", done_o, 1'b0);
    end
    nx();
    #1;
    chk("t2_tx_closed_v", rtr_tx_valid_o, 1'b0);
    chk("t2_tx_closed_r", sldu_tx_ready_o, 1'b0);
    chk("t2_wait_done", done_o, 1'b0);
    chk("t2_wait_busy", busy_o, 1'b1);
    nx();
    rtr_rx_valid_i = 1'b1;
    #1;
    chk("t2_rx_valid", sldu_rx_valid_o, 1'b1);
    chk("t2_done", done_o, 1'b1);
    nx();
    #1;
    chk("t2_busy_drop", busy_o, 1'b0);
    chk("t2_gates_idle", gates(), 1'b0);

    // bypass
    nx();
    req(0, 1, 7, 7);
    hs(1, 1, 1, 1);
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    chk("t3_conf", conf_valid_o, 1'b1);
    chk("t3_bypass", bypass_o, 1'b1);
    chk("t3_dir", dir_o, 1'b0);
    chk("t3_done", done_o, 1'b1);
    chk("t3_gates", gates(), 1'b0);
    nx();
    #1;
    chk("t3_busy_drop", busy_o, 1'b0);
    chk("t3_bypass_hold", bypass_o, 1'b1);
    chk("t3_gates_idle", gates(), 1'b0);
    chk("t3_done_drop", done_o, 1'b0);

    // zero-beat, request held valid across done
    nx();
    req(0, 0, 0, 0);
    #1;
    nx();
    #1;
    chk("t4_conf", conf_valid_o, 1'b1);
    chk("t4_done", done_o, 1'b1);
    chk("t4_no_accept", req_ready_o, 1'b0);
    chk("t4_bypass", bypass_o, 1'b0);
    nx();
    #1;
    chk("t4_accept_next", req_ready_o, 1'b1);
    chk("t4_idle_done", done_o, 1'b0);
    chk("t4_idle_busy", busy_o, 1'b0);
    nx();
    req_valid_i = 1'b0;
    #1;
    chk("t4_done2", done_o, 1'b1);
    chk("t4_conf2", conf_valid_o, 1'b1);
    nx();
    #1;
    chk("t4_busy_drop", busy_o, 1'b0);

    // max beats with random backpressure
    nx();
    req(0, 0, 15, 15);
    hs(0, 0, 0, 0);
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    ndone = 0;
    ntx   = 0;
    nrx   = 0;
    post  = 0;
    for (int c = 0; c < 600; c++) begin
      nx();
      hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      if (rtr_tx_valid_o && rtr_tx_ready_i) ntx++;
      if (sldu_rx_valid_o && sldu_rx_ready_i) nrx++;
      if (done_o) ndone++;
      if (ndone > 0) post++;
      if (post > 6) break;
    end
    chki("t5_done_count", ndone, 1);
    chki("t5_tx_beats", ntx, 15);
    chki("t5_rx_beats", nrx, 15);

    // flush mid-XFER after 2 of 5 tx beats
    nx();
    req(1, 0, 5, 5);
    hs(1, 1, 0, 1);
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nx();
      #1;
      chk("t6_tx_beat", rtr_tx_valid_o, 1'b1);
    end
    nx();
    flush_i = 1'b1;
    #1;
    chk("t6_flush_gates", gates(), 1'b0);
    chk("t6_flush_ready", req_ready_o, 1'b0);
    chk("t6_flush_done", done_o, 1'b0);
    nx();
    flush_i = 1'b0;
    #1;
    chk("t6_idle_busy", busy_o, 1'b0);
    chk("t6_idle_done", done_o, 1'b0);
    chk("t6_idle_gates", gates(), 1'b0);
    chk("t6_dir_kept", dir_o, 1'b1);
    nx();
    req(0, 0, 1, 1);
    hs(1, 1, 1, 1);
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    chk("t6_conf", conf_valid_o, 1'b1);
    nx();
    #1;
    chk("t6_done", done_o, 1'b1);
    nx();
    #1;
    chk("t6_busy_drop", busy_o, 1'b0);

    // flush during CONFIG
    nx();
    req(1, 0, 2, 2);
    #1;
    nx();
    req_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("t6c_conf_supp", conf_valid_o, 1'b0);
    chk("t6c_done", done_o, 1'b0);
    nx();
    flush_i = 1'b0;
    #1;
    chk("t6c_busy", busy_o, 1'b0);
    chk("t6c_dir", dir_o, 1'b1);

    // reset mid-XFER
    nx();
    req(1, 1, 0, 0);
    req_bypass_i = 1'b0;
    req_tx_beats_i = 4'd5;
    req_rx_beats_i = 4'd5;
    #1;
    nx();
    req_valid_i = 1'b0;
    #1;
    nx();
    #1;
    chk("t7_tx_beat", rtr_tx_valid_o, 1'b1);
    nx();
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_gates", gates(), 1'b0);
    chk("t7_rst_done", done_o, 1'b0);
    chk("t7_rst_ready", req_ready_o, 1'b0);
    nx();
    #1;
    chk("t7_busy", busy_o, 1'b0);
    chk("t7_dir", dir_o, 1'b0);
    chk("t7_bypass", bypass_o, 1'b0);
    chk("t7_conf", conf_valid_o, 1'b0);
    chk("t7_gates", gates(), 1'b0);
    nx();
    rst_ni = 1'b1;
    hs(0, 0, 0, 0);
    #1;
    chk("t7_req_ready", req_ready_o, 1'b1);

    nx();
    chki("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
